raster_scheduler: RTL and testbench

Frame-level controller for the `rasterizer` block. It buffers incoming triangles in a small FIFO and clears the wireframe memory at frame start. It then issues each queued triangle to the rasterizer with a start pulse, waiting for completion, and reports frame completion. It also owns the wireframe memory write port, multiplexing its own clear writes with the rasterizer's pixel writes.

---
 rtl/defines_package.sv | 33 +++
 rtl/tri_fifo.sv | 48 ++++
 rtl/raster_scheduler.sv | 137 +++++++++++++
 tb/tb_raster_scheduler.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/defines_package.sv
// Shared wireframe geometry, triangle/colour types and the scheduler state encoding.
package defines_package;

  localparam int WIDTH  = 8;
  localparam int HEIGHT = 4;
  localparam int WIREFRAME_ADDR_SIZE = $clog2(WIDTH * HEIGHT);

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] z;
  } Vertex3D;

  typedef struct packed {
    Vertex3D v0;
    Vertex3D v1;
    Vertex3D v2;
  } Triangle3D;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } Color;

  typedef struct packed {
    Triangle3D triangle;
    Color      color;
  } TriEntry;

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, START, WAIT, DONE} SchedState;

endpackage

// File: rtl/tri_fifo.sv
// Synchronous FIFO of triangle/colour entries; the head is read straight from storage.
module tri_fifo
  import defines_package::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    n_rst,
  input  logic    push,
  input  logic    pop,
  input  TriEntry push_data,
  output TriEntry head,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);

  TriEntry          mem [DEPTH];
  logic    [AW:0]   wr_ptr;
  logic    [AW:0]   rd_ptr;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/raster_scheduler.sv
// Frame controller: clears wireframe memory, then feeds queued triangles to the rasterizer
// one at a time and owns the shared memory write port.
module raster_scheduler
  import defines_package::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic                           frame_start,
  input  logic                           frame_end,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  Triangle3D                      in_triangle,
  input  Color                           in_color,
  output logic                           rast_start,
  output Triangle3D                      rast_triangle,
  output Color                           rast_color,
  input  logic                           rast_done,
  input  logic                           rast_write_en,
  input  logic                           rast_wf_data,
  input  logic [WIREFRAME_ADDR_SIZE-1:0] rast_addr,
  output logic                           write_en,
  output logic                           wf_data,
  output logic [WIREFRAME_ADDR_SIZE-1:0] addr,
  output logic                           busy,
  output logic                           frame_done,
  output logic [CNT_W-1:0]               tri_count
);

  localparam logic [WIREFRAME_ADDR_SIZE-1:0] LAST_ADDR = WIREFRAME_ADDR_SIZE'(WIDTH * HEIGHT - 1);

  SchedState                      state;
  logic [WIREFRAME_ADDR_SIZE-1:0] clr_cnt;
  logic                           end_flag;
  logic                           done_q;
  logic                           fifo_full;
  logic                           fifo_empty;
  logic                           fifo_pop;
  TriEntry                        push_entry;
  TriEntry                        fifo_head;

  assign in_ready   = ~fifo_full;
  assign fifo_pop   = (state == RUN) && !fifo_empty;
  assign push_entry = '{triangle: in_triangle, color: in_color};

  tri_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .n_rst     (n_rst),
    .push      (in_valid & in_ready),
    .pop       (fifo_pop),
    .push_data (push_entry),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Completion is a rising edge of rast_done so a level left high by the previous
  // triangle cannot retire the next one early.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state         <= IDLE;
      clr_cnt       <= '0;
      end_flag      <= 1'b0;
      done_q        <= 1'b0;
      rast_start    <= 1'b0;
      rast_triangle <= '0;
      rast_color    <= '0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      tri_count     <= '0;
    end else begin
      done_q     <= rast_done;
      rast_start <= 1'b0;
      frame_done <= 1'b0;
      if (frame_end && state != IDLE) begin
        end_flag <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (frame_start) begin
            state     <= CLEAR;
            clr_cnt   <= '0;
            tri_count <= '0;
            end_flag  <= 1'b0;
            busy      <= 1'b1;
          end
        end
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LAST_ADDR) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (!fifo_empty) begin
            rast_triangle <= fifo_head.triangle;
            rast_color    <= fifo_head.color;
            rast_start    <= 1'b1;
            state         <= START;
          end else if (end_flag) begin
            frame_done <= 1'b1;
            state      <= DONE;
          end
        end
        START: state <= WAIT;
        WAIT: begin
          if (rast_done && !done_q) begin
            if (tri_count != '1) begin
              tri_count <= tri_count + 1'b1;
            end
            state <= RUN;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Rasterizer pixel writes arriving during CLEAR are simply dropped.
  always_comb begin
    write_en = rast_write_en;
    wf_data  = rast_wf_data;
    addr     = rast_addr;
    if (state == CLEAR) begin
      write_en = 1'b1;
      wf_data  = 1'b0;
      addr     = clr_cnt;
    end
  end

endmodule

// File: tb/tb_raster_scheduler.sv
// Scoreboard bench for raster_scheduler with a simple rasterizer model driving done and pixel writes.
module tb_raster_scheduler;
  import defines_package::*;

  localparam int DEPTH  = 4;
  localparam int CNT_W  = 16;
  localparam int PIXELS = WIDTH * HEIGHT;

  logic                           tb_clk = 1'b0;
  logic                           n_rst = 1'b0;
  logic                           frame_start = 1'b0;
  logic                           frame_end = 1'b0;
  logic                           in_valid = 1'b0;
  logic                           in_ready;
  Triangle3D                      in_triangle = '0;
  Color                           in_color = '0;
  logic                           rast_start;
  Triangle3D                      rast_triangle;
  Color                           rast_color;
  logic                           rast_done = 1'b0;
  logic                           rast_write_en = 1'b0;
  logic                           rast_wf_data = 1'b0;
  logic [WIREFRAME_ADDR_SIZE-1:0] rast_addr = '0;
  logic                           write_en;
  logic                           wf_data;
  logic [WIREFRAME_ADDR_SIZE-1:0] addr;
  logic                           busy;
  logic                           frame_done;
  logic [CNT_W-1:0]               tri_count;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  TriEntry exp_q[$];
  TriEntry cur_entry = '0;
  bit      active = 0;
  bit      pending_at_done = 0;
  int      start_cyc = 0;
  int      last_done_cyc = -100;
  int      done_rises = 0;
  int      starts_in_frame = 0;
  int      starts_total = 0;
  int      frames_done = 0;
  int      clr_first = -1000;
  int      accept_cyc = -1;
  int      first_start_cyc = -2;

  int      exp_frame_tris = 0;
  bit      hold_mode = 0;
  bit      noise = 0;

  raster_scheduler #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk           (tb_clk),
    .n_rst         (n_rst),
    .frame_start   (frame_start),
    .frame_end     (frame_end),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_triangle   (in_triangle),
    .in_color      (in_color),
    .rast_start    (rast_start),
    .rast_triangle (rast_triangle),
    .rast_color    (rast_color),
    .rast_done     (rast_done),
    .rast_write_en (rast_write_en),
    .rast_wf_data  (rast_wf_data),
    .rast_addr     (rast_addr),
    .write_en      (write_en),
    .wf_data       (wf_data),
    .addr          (addr),
    .busy          (busy),
    .frame_done    (frame_done),
    .tri_count     (tri_count)
  );

  always #5 tb_clk = ~tb_clk;

  always @(posedge tb_clk) cyc++;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Monitor and rasterizer model: samples mid-cycle and drives rast_* for the next edge.
  always @(negedge tb_clk) begin
    if (!n_rst) begin
      exp_q.delete();
      active          = 0;
      pending_at_done = 0;
      rast_done       = 1'b0;
      rast_write_en   = 1'b0;
      rast_wf_data    = 1'b0;
      clr_first       = -1000;
    end else begin
      if (frame_start) begin
        clr_first       = cyc + 1;
        done_rises      = 0;
        starts_in_frame = 0;
        pending_at_done = 0;
      end
      if (cyc >= clr_first && cyc < clr_first + PIXELS)
        checkOutput("clear_write", {write_en, wf_data, addr},
                    {1'b1, 1'b0, WIREFRAME_ADDR_SIZE'(cyc - clr_first)});
      else if (write_en || rast_write_en)
        checkOutput("pass_write", {write_en, wf_data, addr}, {rast_write_en, rast_wf_data, rast_addr});
      if (in_valid && in_ready) begin
        exp_q.push_back({in_triangle, in_color});
        accept_cyc = cyc;
      end
      if (rast_start) begin
        starts_in_frame++;
        starts_total++;
        if (starts_in_frame == 1) first_start_cyc = cyc;
        if (exp_q.size() == 0) begin
          checkOutput("start_unexpected", 1, 0);
        end else begin
          cur_entry = exp_q.pop_front();
          checkOutput("start_payload", {rast_triangle, rast_color}, cur_entry);
          if (pending_at_done) checkOutput("start_spacing", cyc - last_done_cyc, 2);
        end
        pending_at_done = 0;
        active          = 1;
        start_cyc       = cyc;
      end
      if (active) begin
        if (cyc - start_cyc == (hold_mode ? 4 : 0)) rast_done = 1'b0;
        if (cyc - start_cyc == 10) begin
          checkOutput("rast_hold", {rast_triangle, rast_color}, cur_entry);
          rast_done       = 1'b1;
          active          = 0;
          last_done_cyc   = cyc;
          done_rises++;
          pending_at_done = (exp_q.size() != 0);
        end
      end
      if (frame_done) begin
        frames_done++;
        checkOutput("tri_count", tri_count, done_rises);
        checkOutput("frame_starts", starts_in_frame, exp_frame_tris);
        checkOutput("frame_done_time", cyc,
                    (done_rises > 0) ? last_done_cyc + 2 : clr_first + PIXELS + 1);
      end
      if (noise) begin
        rast_write_en = 1'($urandom_range(0, 1));
        rast_wf_data  = 1'b1;
        rast_addr     = WIREFRAME_ADDR_SIZE'($urandom);
      end else begin
        rast_write_en = 1'b0;
        rast_wf_data  = 1'b0;
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge tb_clk);
      #1;
    end
  endtask

  function automatic Triangle3D randTri();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[71:0];
  endfunction

  function automatic Color randColor();
    logic [31:0] r;
    r = $urandom;
    return r[11:0];
  endfunction

  task automatic applyStimulus(input Triangle3D t, input Color c);
    int   waited = 0;
    logic ok = 1'b0;
    in_valid    = 1'b1;
    in_triangle = t;
    in_color    = c;
    while (!ok && waited < 300) begin
      ok = in_ready;
      step();
      waited++;
    end
    in_valid = 1'b0;
    if (!ok) checkOutput("push_timeout", 0, 1);
  endtask

  task automatic startFrame(input int n_tris);
    exp_frame_tris = n_tris;
    frame_start    = 1'b1;
    step();
    frame_start    = 1'b0;
  endtask

  task automatic endFrame();
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
  endtask

  task automatic waitFrameDone();
    int target = frames_done + 1;
    int waited = 0;
    while (frames_done < target && waited < 2000) begin
      step();
      waited++;
    end
    checkOutput("frame_done_seen", frames_done >= target, 1);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_in_ready"}, in_ready, 1);
    checkOutput({tag, "_rast_start"}, rast_start, 0);
    checkOutput({tag, "_rast_regs"}, {rast_triangle, rast_color}, 0);
    checkOutput({tag, "_write_en"}, write_en, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_frame_done"}, frame_done, 0);
    checkOutput({tag, "_tri_count"}, tri_count, 0);
  endtask

  initial begin
    int waited;
    step(3);
    n_rst = 1'b1;
    checkResetValues("reset");

    $display("[TB] empty frame");
    startFrame(0);
    checkOutput("busy_in_clear", busy, 1);
    endFrame();
    waitFrameDone();
    checkOutput("busy_idle", busy, 0);

    $display("[TB] three triangles pushed during clear");
    startFrame(3);
    for (int i = 0; i < 3; i++) applyStimulus(randTri(), randColor());
    endFrame();
    waitFrameDone();

    $display("[TB] FIFO overfill with prefetch in IDLE");
    for (int i = 0; i < DEPTH; i++) applyStimulus(randTri(), randColor());
    in_valid    = 1'b1;
    in_triangle = randTri();
    in_color    = randColor();
    checkOutput("in_ready_full", in_ready, 0);
    startFrame(DEPTH + 1);
    endFrame();
    waited = 0;
    while (!in_ready && waited < 300) begin
      step();
      waited++;
    end
    step();
    in_valid = 1'b0;
    checkOutput("fifth_accept_cycle", accept_cyc, first_start_cyc);
    waitFrameDone();

    $display("[TB] rasterizer holds done high between triangles");
    hold_mode = 1;
    startFrame(3);
    for (int i = 0; i < 3; i++) applyStimulus(randTri(), randColor());
    endFrame();
    waitFrameDone();
    hold_mode = 0;

    $display("[TB] rasterizer writes during clear");
    noise = 1;
    startFrame(2);
    for (int i = 0; i < 2; i++) applyStimulus(randTri(), randColor());
    endFrame();
    waitFrameDone();
    noise = 0;
    step(2);

    $display("[TB] reset during WAIT with triangles queued");
    startFrame(3);
    for (int i = 0; i < 3; i++) applyStimulus(randTri(), randColor());
    waited = 0;
    while (starts_total == 0 && waited < 300) begin
      step();
      waited++;
    end
    waited = starts_total;
    while (starts_total == waited && waited < 1000) step();
    step(3);
    n_rst = 1'b0;
    step();
    checkResetValues("midreset");
    step();
    n_rst = 1'b1;
    step();
    startFrame(0);
    endFrame();
    waitFrameDone();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
